// File: rtl/writeback_pkg.sv
// Shared types and default widths for the MEM/WB write-back stage.
// Encodings match the decoder's resultSrc and loadType fields.
package writeback_pkg;

   localparam int DEFAULT_DATA_W     = 32;
   localparam int DEFAULT_REG_ADDR_W = 5;
   localparam int DEFAULT_CNT_W      = 32;

   typedef enum logic [1:0] {
      RES_ALU  = 2'd0,
      RES_MEM  = 2'd1,
      RES_LINK = 2'd2,
      RES_RSVD = 2'd3
   } result_src_t;

   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } load_type_t;

endpackage : writeback_pkg

// File: rtl/writeback_stage_load_extend.sv
// Combinational sub-word extraction and sign/zero extension of load data.
// Little-endian byte lanes; undefined load types fall back to a full word.
module load_extend
   import writeback_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [DATA_W-1:0] readDataW,
   input  logic [1:0]        byteOffW,
   input  logic [2:0]        loadTypeW,
   output logic [DATA_W-1:0] ext_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selects only look at the low 32 bits; off[0] is ignored for halves.
   always_comb begin
      byte_sel = readDataW[{byteOffW, 3'b000} +: 8];
      half_sel = byteOffW[1] ? readDataW[31:16] : readDataW[15:0];
   end

   // NOTE: every output of a combinational block is given a default first so
   // that no path leaves it unassigned, which would infer a latch.
   always_comb begin
      ext_data = readDataW;
      case (loadTypeW)
         LD_LB:   ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LD_LBU:  ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_LH:   ext_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LD_LHU:  ext_data = {{(DATA_W-16){1'b0}}, half_sel};
         default: ext_data = readDataW;
      endcase
   end

endmodule : load_extend

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, write-back result mux and retired-instruction
// counter for the 32-bit pipelined MIPS core.
module writeback_stage
   import writeback_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
   parameter int CNT_W      = DEFAULT_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallW,
   input  logic                  flushW,
   input  logic                  validM,
   input  logic                  regWriteM,
   input  logic [1:0]            resultSrcM,
   input  logic [2:0]            loadTypeM,
   input  logic [1:0]            byteOffM,
   input  logic [DATA_W-1:0]     aluOutM,
   input  logic [DATA_W-1:0]     readDataM,
   input  logic [DATA_W-1:0]     pcPlus8M,
   input  logic [REG_ADDR_W-1:0] writeRegM,
   output logic                  validW,
   output logic                  regWriteW,
   output logic [REG_ADDR_W-1:0] writeRegW,
   output logic [DATA_W-1:0]     resultW,
   output logic [CNT_W-1:0]      retiredCount
);

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      result_src_t           result_src;
      logic [2:0]            load_type;
      logic [1:0]            byte_off;
      logic [DATA_W-1:0]     alu_out;
      logic [DATA_W-1:0]     read_data;
      logic [DATA_W-1:0]     pc_plus8;
      logic [REG_ADDR_W-1:0] write_reg;
   } wb_reg_t;

   wb_reg_t           wb_d, wb_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic [DATA_W-1:0] load_val;

   // Flush only kills the valid/write bits; stale payload is harmless.
   always_comb begin
      wb_d = wb_q;
      if (flushW) begin
         wb_d.valid     = 1'b0;
         wb_d.reg_write = 1'b0;
      end else if (!stallW) begin
         wb_d.valid      = validM;
         wb_d.reg_write  = regWriteM;
         wb_d.result_src = result_src_t'(resultSrcM);
         wb_d.load_type  = loadTypeM;
         wb_d.byte_off   = byteOffM;
         wb_d.alu_out    = aluOutM;
         wb_d.read_data  = readDataM;
         wb_d.pc_plus8   = pcPlus8M;
         wb_d.write_reg  = writeRegM;
      end
   end

   // The instruction currently in WB leaves on any unstalled edge, flushed or not.
   always_comb begin
      cnt_d = cnt_q;
      if (wb_q.valid && !stallW) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   load_extend #(
      .DATA_W (DATA_W)
   ) u_load_extend (
      .readDataW (wb_q.read_data),
      .byteOffW  (wb_q.byte_off),
      .loadTypeW (wb_q.load_type),
      .ext_data  (load_val)
   );

   always_comb begin
      resultW = '0;
      case (wb_q.result_src)
         RES_ALU:  resultW = wb_q.alu_out;
         RES_MEM:  resultW = load_val;
         RES_LINK: resultW = wb_q.pc_plus8;
         default:  resultW = '0;
      endcase
   end

   // Writes to register 0 are dropped here so the register file needs no guard.
   assign validW       = wb_q.valid;
   assign regWriteW    = wb_q.valid & wb_q.reg_write & (wb_q.write_reg != '0);
   assign writeRegW    = wb_q.write_reg;
   assign retiredCount = cnt_q;

endmodule : writeback_stage

// File: doc/writeback_stage.md
# writeback_stage

Parametrised MEM/WB pipeline register and write-back stage for the 32-bit pipelined MIPS core. It captures memory-stage results on `clk` and selects the register-file write value from ALU result, load data or link address. Load data is sub-word extracted and sign/zero-extended. It supports stall and flush, suppresses writes to register 0, and keeps a retired-instruction counter.

## Interface
Parameters:
- `DATA_W`, 32: datapath width; must be a multiple of 16 and at least 32.
- `REG_ADDR_W`, 5: register-file address width.
- `CNT_W`, 32: retired-instruction counter width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stallW`  in  1  hold the WB register contents.
- `flushW`  in  1  load a bubble into the WB register.
- `validM`  in  1  MEM stage holds a real instruction.
- `regWriteM`  in  1  instruction writes the register file.
- `resultSrcM`  in  2  result select: 0 ALU, 1 memory, 2 link, 3 reserved.
- `loadTypeM`  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU.
- `byteOffM`  in  2  low address bits of the load.
- `aluOutM`  in  DATA_W  ALU result.
- `readDataM`  in  DATA_W  raw data-memory word.
- `pcPlus8M`  in  DATA_W  link address.
- `writeRegM`  in  REG_ADDR_W  destination register.
- `validW`  out  1  WB stage holds a real instruction.
- `regWriteW`  out  1  register-file write enable.
- `writeRegW`  out  REG_ADDR_W  register-file write address.
- `resultW`  out  DATA_W  register-file write data and forwarding value.
- `retiredCount`  out  CNT_W  count of instructions that have left WB.

## Operation
- WB register holds all M-stage inputs as `*W` copies.
- Register update per rising edge, in priority order:
  - `flushW`: `validW`=0 and `regWriteW`=0; other fields don't-care, implemented as unchanged.
  - `stallW`: every field holds.
  - Otherwise: every field loads from its M-stage input.
- `regWriteW` = registered `regWriteM` AND registered `validM` AND (`writeRegW` != 0).
- `resultW` is combinational from the registered fields:
  - src 0 → `aluOutW`.
  - src 1 → extended load value.
  - src 2 → `pcPlus8W`.
  - src 3 → 0.
- Load extension uses little-endian lanes:
  - LB/LBU: byte `readDataW[8*off +: 8]`.
  - LH/LHU: half selected by `off[1]`; `off[0]` is ignored (no misalignment trap).
  - LW: full word; offset ignored.
  - Signed loads sign-extend to DATA_W; unsigned loads zero-extend.
  - Undefined `loadType` codes (5–7) behave as LW.
- `retiredCount` increments by 1 on each edge where `validW`=1 and `stallW`=0.
  - It counts the instruction leaving WB, so a flush on that same edge still counts it.
  - Wraps from 2^CNT_W−1 to 0.

## Timing
- Latency: M-stage inputs appear on W outputs one cycle after capture. `resultW` settles in the same cycle, with no extra register.
- `rst` asserted, taking effect immediately and asynchronously:
  - All WB register fields = 0.
  - `validW`=0, `regWriteW`=0, `writeRegW`=0.
  - `resultW`=0, because src=0 and `aluOutW`=0.
  - `retiredCount`=0.
- Reset mid-operation discards the instruction in WB without counting it.
- `stallW` with `flushW`: flush wins.
- A stall held for N cycles keeps `resultW` stable for N+1 cycles, and `retiredCount` advances once, at release.

## Structure
- Package `writeback_pkg` holds:
  - `result_src_t` enum: ALU, MEM, LINK, RSVD.
  - `load_type_t` enum: LW, LB, LBU, LH, LHU.
  - Default width constants.
- Sub-module `load_extend` is purely combinational:
  - Inputs: `readDataW`, `byteOffW`, `loadTypeW`.
  - Output: the extended value.
- The top level holds the WB register, the result mux and the counter.

## Test plan
- Reset, then load ALU result 3, writeReg 5, regWrite 1, src 0 → next cycle `resultW`=3, `regWriteW`=1, `writeRegW`=5; one further clean cycle gives `retiredCount`=1.
- readData 0x80F0_7F01, src 1:
  - LB off 3 → 0xFFFF_FF80.
  - LBU off 1 → 0x0000_007F.
  - LH off 2 → 0xFFFF_80F0.
  - LHU off 0 → 0x0000_7F01.
  - LW → 0x80F0_7F01.
- writeReg 0, regWrite 1 → `regWriteW`=0, `resultW` still driven.
- Stall 3 cycles with new M inputs applied → W outputs unchanged and counter unchanged; on release the counter increments once. Stall+flush on the same edge → `validW`=0.
- CNT_W=4, 16 back-to-back valid instructions → counter wraps 15→0. Assert `rst` mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
